// File: rtl/angle_sweep.sv
// angle_sweep -- emits a sequence of phase angles for a downstream sin/cos stage.
//
// A sweep is started with start (sampled only while idle). The start angle,
// step and sample count are latched, then count samples are presented on
// angle/index with a valid/ready handshake. Each accepted sample advances the
// angle by step, wrapped back into [-PI_FIX, PI_FIX]. Angles are two's
// complement with 8 fractional bits (1.0 = 256).
//
// Optional feature: define ANGLE_SWEEP_LOOP_EN to make the sweep repeat
// indefinitely from the latched start angle. In that mode done pulses once
// per pass, and only abort or reset end the sweep.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   start        request a sweep (idle only)
//   abort        terminate a sweep in progress, no done pulse
//   start_angle  first angle of the sweep
//   step         signed per-sample increment
//   count        number of samples to emit (0 = immediate done)
//   ready        downstream accepts the current angle
//   angle        current angle
//   angle_valid  angle is valid (downstream enable)
//   index        zero-based index of the current sample
//   busy         sweep in progress
//   done         one-cycle pulse at sweep completion
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no sweep; waiting for start
// RUN   | presenting samples; advances on each transfer

module angle_sweep #(
    parameter int WIDTH      = 27,
    parameter int PI_FIX     = 804,
    parameter int TWO_PI_FIX = 1608
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] start_angle,
    input  logic [WIDTH-1:0] step,
    input  logic [15:0]      count,
    input  logic             ready,
    output logic [WIDTH-1:0] angle,
    output logic             angle_valid,
    output logic [15:0]      index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic signed [WIDTH:0]   PI_W     = (WIDTH+1)'(PI_FIX);
    localparam logic signed [WIDTH-1:0] TWO_PI_N = WIDTH'(TWO_PI_FIX);

    state_t           state, state_next;
    logic [WIDTH-1:0] angle_next;
    logic [15:0]      index_next;
    logic [WIDTH-1:0] step_lat, step_next;
    // Samples still to transfer after the current one; zero marks the last.
    logic [15:0]      remaining, remaining_next;
    logic             done_next;

`ifdef ANGLE_SWEEP_LOOP_EN
    logic [WIDTH-1:0] start_lat, start_lat_next;
    logic [15:0]      reload_lat, reload_lat_next;
`endif

    // One extra bit keeps angle+step exact, so the range compare is honest
    // even for the extreme in-range operands.
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] wrapped;

    always_comb begin
        sum = {angle[WIDTH-1], angle} + {step_lat[WIDTH-1], step_lat};
        // The corrected result always fits in WIDTH bits, so the correction
        // can be applied modulo 2^WIDTH.
        if (sum > PI_W) begin
            wrapped = sum[WIDTH-1:0] - TWO_PI_N;
        end else if (sum < -PI_W) begin
            wrapped = sum[WIDTH-1:0] + TWO_PI_N;
        end else begin
            wrapped = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            angle      <= '0;
            index      <= '0;
            step_lat   <= '0;
            remaining  <= '0;
            done       <= 1'b0;
`ifdef ANGLE_SWEEP_LOOP_EN
            start_lat  <= '0;
            reload_lat <= '0;
`endif
        end else begin
            state      <= state_next;
            angle      <= angle_next;
            index      <= index_next;
            step_lat   <= step_next;
            remaining  <= remaining_next;
            done       <= done_next;
`ifdef ANGLE_SWEEP_LOOP_EN
            start_lat  <= start_lat_next;
            reload_lat <= reload_lat_next;
`endif
        end
    end

    always_comb begin
        state_next      = state;
        angle_next      = angle;
        index_next      = index;
        step_next       = step_lat;
        remaining_next  = remaining;
        done_next       = 1'b0;
`ifdef ANGLE_SWEEP_LOOP_EN
        start_lat_next  = start_lat;
        reload_lat_next = reload_lat;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != 16'd0) begin
                        state_next      = RUN;
                        angle_next      = start_angle;
                        index_next      = 16'd0;
                        step_next       = step;
                        remaining_next  = count - 16'd1;
`ifdef ANGLE_SWEEP_LOOP_EN
                        start_lat_next  = start_angle;
                        reload_lat_next = count - 16'd1;
`endif
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort wins over a coincident transfer, which is dropped.
                if (abort) begin
                    state_next = IDLE;
                end else if (ready) begin
                    if (remaining == 16'd0) begin
                        done_next = 1'b1;
`ifdef ANGLE_SWEEP_LOOP_EN
                        angle_next     = start_lat;
                        index_next     = 16'd0;
                        remaining_next = reload_lat;
`else
                        state_next     = IDLE;
`endif
                    end else begin
                        angle_next     = wrapped;
                        index_next     = index + 16'd1;
                        remaining_next = remaining - 16'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign angle_valid = (state == RUN);
    assign busy        = (state == RUN);

endmodule

// File: tb/tb_angle_sweep.sv
module tb_angle_sweep;

    localparam int W      = 27;
    localparam int PI     = 804;
    localparam int TWO_PI = 1608;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic signed [W-1:0] start_angle;
    logic signed [W-1:0] step;
    logic [15:0]         count;
    logic                ready;
    logic signed [W-1:0] angle;
    logic                angle_valid;
    logic [15:0]         index;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    angle_sweep #(.WIDTH(W), .PI_FIX(PI), .TWO_PI_FIX(TWO_PI)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .start_angle (start_angle),
        .step        (step),
        .count       (count),
        .ready       (ready),
        .angle       (angle),
        .angle_valid (angle_valid),
        .index       (index),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: next angle = angle + step folded back into [-pi, pi].
    function automatic int wrap_add(input int a, input int s);
        int r;
        r = a + s;
        if (r > PI)       r = r - TWO_PI;
        else if (r < -PI) r = r + TWO_PI;
        return r;
    endfunction

    // One single-pass sweep against a precomputed list of expected angles.
    // Inputs are scrambled and start toggled during the sweep to show that the
    // latched parameters are used and start is ignored while running.
    task automatic sweep(input int sa, input int st, input int cnt,
                         input bit rnd_ready, input logic [31:0] ready_mask,
                         input int abort_at, input bit abort_with_start);
        int exp_a[$];
        int a;
        int idx;
        int cyc;
        int limit;
        bit go;
        a = sa;
        for (int i = 0; i < cnt; i++) begin
            exp_a.push_back(a);
            a = wrap_add(a, st);
        end
        start       = 1'b1;
        abort       = abort_with_start;
        start_angle = W'(sa);
        step        = W'(st);
        count       = 16'(cnt);
        ready       = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        idx   = 0;
        cyc   = 0;
        limit = 8 * cnt + 16;
        while (idx < cnt && cyc < limit) begin
            chk("valid", angle_valid, 1);
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            chk("angle", angle, exp_a[idx]);
            chk("index", index, idx);
            start       = 1'($urandom_range(1));
            start_angle = W'($urandom);
            step        = W'($urandom);
            count       = 16'($urandom);
            if (rnd_ready) ready = 1'($urandom_range(1));
            else           ready = (cyc < 32) ? ready_mask[cyc] : 1'b1;
            if (idx == abort_at) abort = 1'b1;
            go = ready;
            tick();
            cyc++;
            if (abort) begin
                abort = 1'b0;
                start = 1'b0;
                chk("abort_valid", angle_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                tick();
                chk("abort_no_done", done, 0);
                chk("abort_idle", busy, 0);
                return;
            end
            if (go) idx++;
        end
        start = 1'b0;
        chk("sweep_progress", idx, cnt);
        chk("end_valid", angle_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        tick();
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        ready       = 1'b1;
        start_angle = '0;
        step        = '0;
        count       = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_angle", angle, 0);
        chk("rst_index", index, 0);
        chk("rst_valid", angle_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // abort alone in idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        // count of zero: no sample, done next cycle
        start = 1'b1;
        count = 16'd0;
        tick();
        start = 1'b0;
        chk("cnt0_valid", angle_valid, 0);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_done", done, 1);
        tick();
        chk("cnt0_done_clr", done, 0);

`ifdef ANGLE_SWEEP_LOOP_EN
        start       = 1'b1;
        start_angle = W'(10);
        step        = W'(5);
        count       = 16'd2;
        ready       = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2; k++) begin
                chk("loop_angle", angle, (k == 0) ? 10 : 15);
                chk("loop_index", index, k);
                chk("loop_busy", busy, 1);
                chk("loop_valid", angle_valid, 1);
                chk("loop_done", done, (p > 0 && k == 0) ? 1 : 0);
                tick();
            end
        end
        chk("loop_done_last", done, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("loop_abort_valid", angle_valid, 0);
        chk("loop_abort_busy", busy, 0);
        chk("loop_abort_done", done, 0);
        sweep(100, -30, 100, 1'b1, '1, 7, 1'b0);
`else
        sweep(0, 100, 10, 1'b0, '1, -1, 1'b0);
        sweep(-800, -10, 3, 1'b0, '1, -1, 1'b0);
        sweep(0, 1, 4, 1'b0, 32'hFFFF_FFF1, -1, 1'b0);
        sweep(200, 300, 100, 1'b0, '1, 5, 1'b0);
        sweep(804, 804, 6, 1'b0, '1, -1, 1'b1);
        sweep(-804, -804, 5, 1'b1, '1, -1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            sweep(int'($urandom_range(2 * PI)) - PI,
                  int'($urandom_range(2 * PI)) - PI,
                  int'($urandom_range(40, 1)), 1'b1, '1, -1, 1'b0);
        end
`endif

        // reset mid-sweep together with start
        start       = 1'b1;
        start_angle = W'(300);
        step        = W'(-50);
        count       = 16'd100;
        ready       = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_index", index, 3);
        chk("pre_reset_angle", angle, 150);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("mid_rst_angle", angle, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_valid", angle_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (3) tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
